// File: rtl/eth_rx_buf_pkg.sv
// eth_rx_buf_pkg
//   Shared types and constants for the Ethernet receive store-and-forward
//   buffer: the stored beat layout, the write-side FSM states, the beat and
//   statistic widths, and the saturation-free wrapping counter increment.
package eth_rx_buf_pkg;

    localparam int BEAT_W = 73;
    localparam int STAT_W = 32;

    // One stored beat; packed so it maps 1:1 onto a BEAT_W-bit RAM word.
    typedef struct packed {
        logic        last;
        logic [7:0]  keep;
        logic [63:0] data;
    } beat_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECV    = 2'd1,
        DISCARD = 2'd2
    } wr_state_e;

    // Wrapping statistic increment.
    function automatic logic [STAT_W-1:0] stat_inc(input logic [STAT_W-1:0] value,
                                                   input logic              en);
        return value + {{(STAT_W-1){1'b0}}, en};
    endfunction

endpackage

// File: rtl/eth_rx_buf_ram.sv
// eth_rx_buf_ram
//   Simple dual-port RAM, one write port and one registered read port, both
//   on the same clock; written so that it infers block RAM. The read
//   register has a synchronous reset so the buffer output is zero after reset.
// Ports:
//   clock, reset          clock and synchronous active-high reset (read reg only)
//   wr_en/wr_addr/wr_data write port
//   rd_en/rd_addr         read request; rd_data updates on the next edge
//   rd_data               registered read data, held while rd_en is low
module eth_rx_buf_ram #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 73
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_r [0:(2**ADDR_W)-1];

    // Storage write port.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered read port; holds its value while no read is issued.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem_r[rd_addr];
        end
    end

endmodule

// File: rtl/eth_rx_frame_buffer.sv
// eth_rx_frame_buffer
//   Store-and-forward receive buffer between the MAC receive AXI-Stream and
//   the core. A frame becomes visible downstream only after its last beat has
//   been received without error. Errored, oversize and overflowing frames are
//   dropped whole by rewinding the speculative write pointer; the input side
//   never backpressures.
// Ports:
//   clock, reset      GT user clock, synchronous active-high reset
//   s_axis_*          64-bit MAC receive stream (tready is 1 outside reset)
//   m_axis_*          64-bit stream to the core, driven from registers
//   overflow          one-cycle pulse when a frame is dropped for lack of space
//   stat_frames_*     32-bit wrapping counters (ok / bad / overflow)
// Configuration:
//   ETH_RX_STATS_EN   when defined the statistic counters are built,
//                     otherwise the stat_* ports are tied to zero.
module eth_rx_frame_buffer
    import eth_rx_buf_pkg::*;
#(
    parameter int DEPTH_LOG2 = 9,
    parameter int MAX_BEATS  = 190
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [63:0]       s_axis_tdata,
    input  logic [7:0]        s_axis_tkeep,
    input  logic              s_axis_tlast,
    input  logic              s_axis_tuser,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [63:0]       m_axis_tdata,
    output logic [7:0]        m_axis_tkeep,
    output logic              m_axis_tlast,
    output logic              m_axis_tuser,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              overflow,
    output logic [STAT_W-1:0] stat_frames_ok,
    output logic [STAT_W-1:0] stat_frames_bad,
    output logic [STAT_W-1:0] stat_frames_ovf
);

    localparam int PTR_W = DEPTH_LOG2 + 1;
    localparam int CNT_W = $clog2(MAX_BEATS + 2);
    localparam logic [PTR_W-1:0] FULL_LVL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_BEATS);

    wr_state_e        state_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] wr_commit_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] beat_cnt_r;
    logic             err_r;
    logic             first_r;
    logic             overflow_r;
    logic             ok_evt_r;
    logic             bad_evt_r;

    logic             beat_s;
    logic             full_s;
    logic             oversize_s;
    logic             wr_en_s;
    logic             rd_en_s;
    beat_t            wr_beat_s;
    beat_t            ram_q_s;
    beat_t            skid_r;
    beat_t            out_beat_s;
    logic             ram_v_r;
    logic             skid_v_r;

    assign s_axis_tready = ~reset;
    assign beat_s        = s_axis_tvalid & ~reset;
    // Occupancy uses the registered read pointer, i.e. before this cycle's read.
    assign full_s        = ((wr_ptr_r - rd_ptr_r) == FULL_LVL);
    assign oversize_s    = (beat_cnt_r == MAX_CNT);
    assign wr_beat_s     = '{last: s_axis_tlast, keep: s_axis_tkeep, data: s_axis_tdata};

    // RAM write enable: any accepted beat of a frame that still has room.
    always_comb begin
        wr_en_s = 1'b0;
        case (state_r)
            IDLE:    wr_en_s = beat_s & ~first_r & ~full_s;
            RECV:    wr_en_s = beat_s & ~full_s & ~oversize_s;
            default: wr_en_s = 1'b0;
        endcase
    end

    // Write-side frame FSM: speculative write, commit on good tlast, rewind on drop.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= IDLE;
            wr_ptr_r    <= '0;
            wr_commit_r <= '0;
            beat_cnt_r  <= '0;
            err_r       <= 1'b0;
            first_r     <= 1'b1;
            overflow_r  <= 1'b0;
            ok_evt_r    <= 1'b0;
            bad_evt_r   <= 1'b0;
        end else begin
            first_r    <= 1'b0;
            overflow_r <= 1'b0;
            ok_evt_r   <= 1'b0;
            bad_evt_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (beat_s) begin
                        if (first_r) begin
                            // A beat right after reset belongs to a frame whose head was lost.
                            if (!s_axis_tlast) begin
                                state_r <= DISCARD;
                            end
                        end else if (full_s) begin
                            overflow_r <= 1'b1;
                            if (!s_axis_tlast) begin
                                state_r <= DISCARD;
                            end
                        end else if (s_axis_tlast) begin
                            if (s_axis_tuser) begin
                                bad_evt_r <= 1'b1;
                            end else begin
                                wr_ptr_r    <= wr_ptr_r + PTR_W'(1);
                                wr_commit_r <= wr_ptr_r + PTR_W'(1);
                                ok_evt_r    <= 1'b1;
                            end
                        end else begin
                            wr_ptr_r   <= wr_ptr_r + PTR_W'(1);
                            beat_cnt_r <= CNT_W'(1);
                            err_r      <= s_axis_tuser;
                            state_r    <= RECV;
                        end
                    end
                end
                RECV: begin
                    if (beat_s) begin
                        if (full_s) begin
                            wr_ptr_r   <= wr_commit_r;
                            overflow_r <= 1'b1;
                            state_r    <= s_axis_tlast ? IDLE : DISCARD;
                        end else if (oversize_s) begin
                            wr_ptr_r  <= wr_commit_r;
                            bad_evt_r <= 1'b1;
                            state_r   <= s_axis_tlast ? IDLE : DISCARD;
                        end else if (s_axis_tlast) begin
                            if (err_r | s_axis_tuser) begin
                                wr_ptr_r  <= wr_commit_r;
                                bad_evt_r <= 1'b1;
                            end else begin
                                wr_ptr_r    <= wr_ptr_r + PTR_W'(1);
                                wr_commit_r <= wr_ptr_r + PTR_W'(1);
                                ok_evt_r    <= 1'b1;
                            end
                            state_r <= IDLE;
                        end else begin
                            wr_ptr_r   <= wr_ptr_r + PTR_W'(1);
                            beat_cnt_r <= beat_cnt_r + CNT_W'(1);
                            err_r      <= err_r | s_axis_tuser;
                        end
                    end
                end
                DISCARD: begin
                    if (beat_s && s_axis_tlast) begin
                        state_r <= IDLE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    eth_rx_buf_ram #(
        .ADDR_W (DEPTH_LOG2),
        .DATA_W (BEAT_W)
    ) u_ram (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (wr_en_s),
        .wr_addr (wr_ptr_r[DEPTH_LOG2-1:0]),
        .wr_data (wr_beat_s),
        .rd_en   (rd_en_s),
        .rd_addr (rd_ptr_r[DEPTH_LOG2-1:0]),
        .rd_data (ram_q_s)
    );

    // Read only committed beats, and only while the skid slot is free: a read
    // issued with an unconsumed RAM output moves that output into the skid.
    assign rd_en_s = (rd_ptr_r != wr_commit_r) & ~skid_v_r;

    // Output pipeline: RAM read register is the head, skid holds the older beat.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_r <= '0;
            ram_v_r  <= 1'b0;
            skid_v_r <= 1'b0;
            skid_r   <= '0;
        end else begin
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            if (skid_v_r) begin
                if (m_axis_tready) begin
                    skid_v_r <= 1'b0;
                end
            end else if (rd_en_s && ram_v_r && !m_axis_tready) begin
                skid_r   <= ram_q_s;
                skid_v_r <= 1'b1;
            end
            if (rd_en_s) begin
                ram_v_r <= 1'b1;
            end else if (!skid_v_r && m_axis_tready) begin
                ram_v_r <= 1'b0;
            end
        end
    end

    assign out_beat_s    = skid_v_r ? skid_r : ram_q_s;
    assign m_axis_tvalid = skid_v_r | ram_v_r;
    assign m_axis_tdata  = out_beat_s.data;
    assign m_axis_tkeep  = out_beat_s.keep;
    assign m_axis_tlast  = out_beat_s.last;
    assign m_axis_tuser  = 1'b0;
    assign overflow      = overflow_r;

`ifdef ETH_RX_STATS_EN
    logic [STAT_W-1:0] ok_cnt_r;
    logic [STAT_W-1:0] bad_cnt_r;
    logic [STAT_W-1:0] ovf_cnt_r;

    // Per-outcome frame counters; each frame raises exactly one event.
    always_ff @(posedge clock) begin
        if (reset) begin
            ok_cnt_r  <= '0;
            bad_cnt_r <= '0;
            ovf_cnt_r <= '0;
        end else begin
            ok_cnt_r  <= stat_inc(ok_cnt_r, ok_evt_r);
            bad_cnt_r <= stat_inc(bad_cnt_r, bad_evt_r);
            ovf_cnt_r <= stat_inc(ovf_cnt_r, overflow_r);
        end
    end

    assign stat_frames_ok  = ok_cnt_r;
    assign stat_frames_bad = bad_cnt_r;
    assign stat_frames_ovf = ovf_cnt_r;
`else
    logic unused_evt_s;
    assign unused_evt_s    = ok_evt_r ^ bad_evt_r;
    assign stat_frames_ok  = '0;
    assign stat_frames_bad = '0;
    assign stat_frames_ovf = '0;
`endif

endmodule

// File: tb/tb_eth_rx_frame_buffer.sv
// tb_eth_rx_frame_buffer
//   Directed + randomized bench for eth_rx_frame_buffer. A frame-level model
//   decides from the frame's length and error beats whether it is delivered,
//   and a scoreboard queue holds the beats the core must see. A second,
//   small-depth instance is used for the overflow scenario.
`timescale 1ns/1ps
module tb_eth_rx_frame_buffer;

    localparam int MAXB = 190;

    logic        clock    = 1'b0;
    logic        reset    = 1'b1;
    logic [63:0] s_tdata  = 64'd0;
    logic [7:0]  s_tkeep  = 8'd0;
    logic        s_tlast  = 1'b0;
    logic        s_tuser  = 1'b0;
    logic        s_tvalid = 1'b0;

    logic        s_tready_a, s_tready_b;
    logic [63:0] m_tdata_a, m_tdata_b;
    logic [7:0]  m_tkeep_a, m_tkeep_b;
    logic        m_tlast_a, m_tlast_b, m_tuser_a, m_tuser_b, m_tvalid_a, m_tvalid_b;
    logic        m_ready_a = 1'b1;
    logic        m_ready_b = 1'b1;
    logic        ovf_a, ovf_b;
    logic [31:0] ok_a, bad_a, ovfc_a, ok_b, bad_b, ovfc_b;

    int          n_vec = 0;
    int          n_err = 0;
    int          mdl_ok = 0;
    int          mdl_bad = 0;
    int          ovf_pulses_a = 0;
    int          ovf_pulses_b = 0;
    bit          rnd_ready = 1'b0;
    logic        ready_a_val = 1'b1;
    logic [72:0] exp_q[$];
    logic [72:0] got_b[$];
    logic [72:0] last_frame[$];

    always #5 clock = ~clock;

    eth_rx_frame_buffer dut (
        .clock(clock), .reset(reset),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
        .s_axis_tuser(s_tuser), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready_a),
        .m_axis_tdata(m_tdata_a), .m_axis_tkeep(m_tkeep_a), .m_axis_tlast(m_tlast_a),
        .m_axis_tuser(m_tuser_a), .m_axis_tvalid(m_tvalid_a), .m_axis_tready(m_ready_a),
        .overflow(ovf_a), .stat_frames_ok(ok_a), .stat_frames_bad(bad_a),
        .stat_frames_ovf(ovfc_a)
    );

    eth_rx_frame_buffer #(.DEPTH_LOG2(4), .MAX_BEATS(MAXB)) dut_small (
        .clock(clock), .reset(reset),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
        .s_axis_tuser(s_tuser), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready_b),
        .m_axis_tdata(m_tdata_b), .m_axis_tkeep(m_tkeep_b), .m_axis_tlast(m_tlast_b),
        .m_axis_tuser(m_tuser_b), .m_axis_tvalid(m_tvalid_b), .m_axis_tready(m_ready_b),
        .overflow(ovf_b), .stat_frames_ok(ok_b), .stat_frames_bad(bad_b),
        .stat_frames_ovf(ovfc_b)
    );

    task automatic chk(input string tag, input logic [72:0] obs, input logic [72:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int stat_exp(input int v);
`ifdef ETH_RX_STATS_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    // Sends one frame; the model then decides whether it must come out.
    task automatic send_frame(input int n, input logic [7:0] last_keep, input int err_beat);
        logic [72:0] beats[$];
        for (int i = 0; i < n; i++) begin
            s_tdata  = {$urandom, $urandom};
            s_tkeep  = (i == n - 1) ? last_keep : 8'hFF;
            s_tlast  = (i == n - 1);
            s_tuser  = (i == err_beat);
            s_tvalid = 1'b1;
            beats.push_back({s_tlast, s_tkeep, s_tdata});
            @(posedge clock); #1;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
        last_frame = beats;
        if (err_beat >= 0 || n > MAXB) begin
            mdl_bad++;
        end else begin
            mdl_ok++;
            foreach (beats[i]) exp_q.push_back(beats[i]);
        end
    endtask

    task automatic drive_beat(input logic last);
        s_tdata  = {$urandom, $urandom};
        s_tkeep  = 8'hFF;
        s_tlast  = last;
        s_tuser  = 1'b0;
        s_tvalid = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic wait_drain(input string tag);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 4000) begin
            @(posedge clock);
            k++;
        end
        repeat (4) @(posedge clock);
        #1;
        chk(tag, 73'(exp_q.size()), 73'd0);
    endtask

    task automatic check_stats(input string tag);
        chk({tag, "_ok"},  73'(ok_a),   73'(stat_exp(mdl_ok)));
        chk({tag, "_bad"}, 73'(bad_a),  73'(stat_exp(mdl_bad)));
        chk({tag, "_ovf"}, 73'(ovfc_a), 73'd0);
    endtask

    // Ready generator for the main instance.
    initial begin
        forever begin
            @(posedge clock); #1;
            if (rnd_ready) m_ready_a = 1'($urandom_range(0, 1));
            else           m_ready_a = ready_a_val;
        end
    end

    // Main-instance scoreboard and stall-stability monitor.
    initial begin
        logic        hold_v;
        logic [72:0] hold_beat;
        logic [72:0] obs;
        logic [72:0] e;
        hold_v = 1'b0;
        hold_beat = 73'd0;
        forever begin
            @(negedge clock);
            obs = {m_tlast_a, m_tkeep_a, m_tdata_a};
            if (reset) begin
                hold_v = 1'b0;
            end else begin
                if (ovf_a) ovf_pulses_a++;
                if (hold_v) begin
                    chk("stall_valid", 73'(m_tvalid_a), 73'd1);
                    chk("stall_beat", obs, hold_beat);
                end
                if (m_tvalid_a && m_ready_a) begin
                    chk("out_tuser", 73'(m_tuser_a), 73'd0);
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : {73{1'bx}};
                    chk("out_beat", obs, e);
                end
                hold_v    = m_tvalid_a && !m_ready_a;
                hold_beat = obs;
            end
        end
    end

    // Small-instance collector.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (ovf_b) ovf_pulses_b++;
                if (m_tvalid_b && m_ready_b) got_b.push_back({m_tlast_b, m_tkeep_b, m_tdata_b});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [72:0] fb[$];
        int n, eb, g, ovf_b0;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        chk("rst_tready", 73'(s_tready_a), 73'd0);
        chk("rst_tvalid", 73'(m_tvalid_a), 73'd0);
        chk("rst_tbeat", {m_tlast_a, m_tkeep_a, m_tdata_a}, 73'd0);
        chk("rst_tuser", 73'(m_tuser_a), 73'd0);
        chk("rst_overflow", 73'(ovf_a), 73'd0);
        chk("rst_stats", {9'd0, ok_a, bad_a}, 73'd0);
        reset = 1'b0;
        @(posedge clock); #1;
        chk("tready_after_rst", 73'(s_tready_a), 73'd1);

        // Latency of the first good frame, then back-to-back frames
        send_frame(8, 8'hFF, -1);
        @(negedge clock);
        chk("latency_n1", 73'(m_tvalid_a), 73'd0);
        @(negedge clock);
        chk("latency_n2", 73'(m_tvalid_a), 73'd1);
        @(posedge clock); #1;
        for (int f = 0; f < 9; f++) send_frame(8, 8'hFF, -1);
        wait_drain("b2b_drain");
        check_stats("b2b");

        // Errored frame followed by a good frame
        send_frame(8, 8'hFF, 2);
        send_frame(8, 8'hFF, -1);
        wait_drain("tuser_drain");
        check_stats("tuser");

        // Oversize frame, then a maximum-length frame and a short one
        send_frame(200, 8'hFF, -1);
        send_frame(MAXB, 8'hFF, -1);
        send_frame(8, 8'h0F, -1);
        wait_drain("oversize_drain");
        check_stats("oversize");

        // Random backpressure with 60-byte frames, then random frames
        rnd_ready = 1'b1;
        for (int f = 0; f < 24; f++) begin
            n  = $urandom_range(1, 10);
            eb = ($urandom_range(0, 4) == 0) ? $urandom_range(0, n - 1) : -1;
            if (f < 8) send_frame(8, 8'h0F, -1);
            else       send_frame(n, 8'($urandom_range(1, 255)), eb);
            g = $urandom_range(0, 6);
            repeat (g) begin @(posedge clock); #1; end
        end
        ready_a_val = 1'b1;
        rnd_ready   = 1'b0;
        wait_drain("random_drain");
        check_stats("random");

        // Reset with a committed frame stuck and another frame in flight
        ready_a_val = 1'b0;
        send_frame(4, 8'hFF, -1);
        for (int i = 0; i < 3; i++) drive_beat(1'b0);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        exp_q.delete();
        mdl_ok  = 0;
        mdl_bad = 0;
        for (int i = 0; i < 3; i++) drive_beat(i == 2);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        ready_a_val = 1'b1;
        repeat (10) @(posedge clock);
        #1;
        chk("rst_mid_no_output", 73'(m_tvalid_a), 73'd0);
        check_stats("rst_mid_pre");
        send_frame(6, 8'hFF, -1);
        wait_drain("rst_mid_drain");
        check_stats("rst_mid_post");

        // Overflow on the 16-entry instance
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        mdl_ok  = 0;
        mdl_bad = 0;
        m_ready_b = 1'b0;
        @(posedge clock); #1;
        got_b.delete();
        ovf_b0 = ovf_pulses_b;
        send_frame(12, 8'hFF, -1);
        fb = last_frame;
        send_frame(12, 8'hFF, -1);
        repeat (4) @(posedge clock);
        #1;
        chk("ovf_pulses", 73'(ovf_pulses_b - ovf_b0), 73'd1);
        chk("ovf_stat_ovf", 73'(ovfc_b), 73'(stat_exp(1)));
        chk("ovf_stat_ok", 73'(ok_b), 73'(stat_exp(1)));
        chk("ovf_stat_bad", 73'(bad_b), 73'd0);
        chk("ovf_stalled_out", 73'(got_b.size()), 73'd0);
        m_ready_b = 1'b1;
        repeat (40) @(posedge clock);
        #1;
        chk("ovf_out_count", 73'(got_b.size()), 73'd12);
        for (int i = 0; i < 12; i++) begin
            chk("ovf_out_beat", (i < got_b.size()) ? got_b[i] : {73{1'bx}}, fb[i]);
        end
        wait_drain("final_drain");
        check_stats("final");
        chk("main_no_overflow", 73'(ovf_pulses_a), 73'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
